// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory request/acknowledge bus
interface pc_sequencer_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;
   modport master (output req, addr, input ack, rdata);
   modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch handshake and next-PC selection for the MIPS core
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   pc_sequencer_if.master imem,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   input  logic        stall,
   input  logic        nxt_valid,
   input  logic [1:0]  nxt_sel,
   input  logic        br_taken,
   input  logic [31:0] rs_val,
   output logic        fault
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} state_t;
   state_t        state, state_nx;
   logic [31:0]   pc_nx, instr_nx, pc4, br_off, next_pc;
   logic [CW-1:0] cnt, cnt_nx;
   logic          commit, jr_bad;
   assign pc4     = pc + 32'd4;
   assign br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
   // jump region comes from pc4, so a jump in the last slot of a region lands in the next one
   assign next_pc = nxt_sel == 2'b00 ? pc4 :
                    nxt_sel == 2'b01 ? (br_taken ? pc4 + br_off : pc4) :
                    nxt_sel == 2'b10 ? {pc4[31:28], instr[25:0], 2'b00} : rs_val;
   assign commit  = nxt_valid && !stall;
   assign jr_bad  = nxt_sel == 2'b11 && rs_val[1:0] != 2'b00;
   assign imem.req    = state == FETCH;
   assign imem.addr   = pc;
   assign instr_valid = state == EXEC;
   assign fault       = state == FAULT;
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      instr_nx = instr;
      cnt_nx   = cnt;
      case (state)
         IDLE: state_nx = FETCH;
         FETCH: begin
            cnt_nx   = imem.ack ? '0 : cnt + 1'b1;
            instr_nx = imem.ack ? imem.rdata : instr;
            state_nx = imem.ack ? EXEC : cnt == TLAST ? FAULT : FETCH;
         end
         EXEC: begin
            state_nx = !commit ? EXEC : jr_bad ? FAULT : FETCH;
            pc_nx    = commit && !jr_bad ? next_pc : pc;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         pc    <= RESET_PC;
         instr <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         instr <= instr_nx;
         cnt   <= cnt_nx;
      end
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch and next-PC controller for the MIPS core. It owns the program counter and runs the instruction-memory request/acknowledge handshake. It holds each fetched instruction for the execute stage, then selects the next PC from sequential, branch, jump or register targets. The jump target is the shift-left-2 aggregate of the PC upper nibble and the 26-bit instruction field; this block is the sequencer that drives and consumes that datapath.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- TIMEOUT, 16, maximum consecutive FETCH cycles without imem_ack before a fault (minimum 1)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; always equals pc
- imem_ack  in  1  memory acknowledge; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  captured instruction
- instr_valid  out  1  instr is held for execute
- pc  out  32  address of the current instruction
- stall  in  1  execute-stage hold; blocks nxt_valid
- nxt_valid  in  1  execute stage commits the next-PC decision
- nxt_sel  in  2  00 sequential, 01 branch, 10 jump, 11 jr
- br_taken  in  1  branch outcome, used when nxt_sel=01
- rs_val  in  32  register target, used when nxt_sel=11
- fault  out  1  sticky error flag (timeout or misaligned jr)

## Operation
- States: IDLE, FETCH, EXEC, FAULT.
- IDLE: entered on reset. Moves to FETCH on the first clock edge with rst=1.
- FETCH:
  - imem_req=1.
  - If imem_ack=1: instr<=imem_rdata, timeout counter cleared, go to EXEC.
  - Otherwise the counter increments.
- EXEC:
  - instr_valid=1, imem_req=0.
  - If nxt_valid=1 and stall=0: pc<=next_pc, go to FETCH.
  - If stall=1, hold everything.
- next_pc, with pc4 = pc + 4 (mod 2^32):
  - 00: pc4
  - 01: br_taken ? pc4 + ({{14{instr[15]}}, instr[15:0], 2'b00}) : pc4 (32-bit wrap)
  - 10: {pc4[31:28], instr[25:0], 2'b00}
  - 11: rs_val
- Misaligned jr:
  - Condition: nxt_sel=11, rs_val[1:0]≠0, and the commit conditions are met.
  - Result: go to FAULT and leave pc unchanged.
- Timeout: if TIMEOUT consecutive FETCH cycles pass without imem_ack, go to FAULT. An ack on the TIMEOUT-th cycle is accepted normally.
- FAULT: imem_req=0, instr_valid=0, fault=1. Absorbing state; only reset exits it.
- Inputs outside their state are ignored: imem_ack outside FETCH, nxt_valid outside EXEC.
- nxt_sel=01 with br_taken=0 gives pc4. br_taken is ignored for the other selections.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, instr=0
  - imem_req=0, instr_valid=0, fault=0, timeout counter=0
- Outputs are registered or decoded from state only. There is no combinational path from any input to an output.
- First imem_req=1 appears one cycle after rst deasserts (the IDLE→FETCH edge).
- Best-case throughput: 2 cycles per instruction (ack on the first FETCH cycle, commit on the first EXEC cycle).
- instr and instr_valid update on the edge after the ack. pc updates on the commit edge, and imem_addr tracks it in the same cycle.
- fault rises on the edge that closes the TIMEOUT-th ack-less FETCH cycle, or on the misaligned-jr commit edge.
- rst=0 in any state, mid-handshake included: outputs take reset values immediately with no clock edge. A pending request is dropped.

## Test plan
- **Jump:** reset, release; ack with 32'h0800_0010; commit nxt_sel=10 → pc=32'h0000_0040, imem_req=1 on the next cycle.
- **Branch:** from pc=32'h0040_0000, instr imm16=16'hFFFF:
  - br_taken=1 → pc=32'h0040_0000
  - br_taken=0 → pc=32'h0040_0004
  - ack on every first FETCH cycle → exactly 2 cycles per instruction
- **Jump region boundary:** jr with rs_val=32'h3FFF_FFFC, then fetch a jump with instr[25:0]=0 → pc=32'h4000_0000 (region comes from pc4, not pc).
- **Misaligned jr:** jr with rs_val=32'h0040_0002 → fault=1 after the commit edge, pc unchanged, imem_req=0 permanently; later nxt_valid and imem_ack pulses have no effect.
- **Timeout:** TIMEOUT=16.
  - Ack on the 16th FETCH cycle → EXEC, fault=0.
  - No ack → fault=1 after the 16th cycle.
  - rst=0 then 1 → fault=0, pc=RESET_PC.
- **Stall and async reset:** in EXEC, hold stall=1 with nxt_valid=1 for 5 cycles → pc and instr stable. Drop rst mid-cycle → outputs reset before the next clock edge.
